// File: rtl/stq_pkg.sv
// Shared sizing and types for the store-queue drain controller.
package stq_pkg;

  localparam int STQ_DEPTH = 16;
  localparam int STQ_INDEX = 4;
  localparam int STQ_WIDTH = 8;

  // Opaque STQ RAM payload (address+data+size).
  typedef logic [STQ_WIDTH-1:0] stq_payload_t;

  // Occupancy counts need one extra bit to represent a completely full queue.
  typedef logic [STQ_INDEX:0] stq_cnt_t;

endpackage

// File: rtl/stq_ptr_wrap.sv
// Modulo-DEPTH queue pointer: advances by 0-2 per cycle, or loads a new value.
module stq_ptr_wrap #(
  parameter int INDEX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       add,
  input  logic             load,
  input  logic [INDEX-1:0] load_val,
  output logic [INDEX-1:0] ptr
);

  // Pointer register; wraps naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else begin
      ptr <= ptr + INDEX'(add);
    end
  end

endmodule

// File: rtl/stq_drain_ctrl.sv
// Store-queue occupancy and drain controller: allocates at dispatch, tracks
// commits, reads committed entries in order and presents them to the D-cache
// through a one-entry valid/ready output register.
module stq_drain_ctrl
  import stq_pkg::*;
#(
  parameter int DEPTH = STQ_DEPTH,
  parameter int INDEX = STQ_INDEX,
  parameter int WIDTH = STQ_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       allocCnt_i,
  input  logic [1:0]       commitCnt_i,
  input  logic             flush_i,
  output logic [INDEX-1:0] tail_o,
  output logic [INDEX:0]   freeCnt_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [INDEX-1:0] ramAddr_o,
  input  logic [WIDTH-1:0] ramData_i,
  output logic             dcValid_o,
  output logic [WIDTH-1:0] dcData_o,
  input  logic             dcReady_i,
  output logic             errSticky_o
);

  logic [INDEX-1:0] head;
  logic [INDEX-1:0] commit_ptr;
  logic [INDEX-1:0] commit_nxt;
  logic [INDEX:0]   cnt;
  logic [INDEX:0]   ccnt;
  logic [INDEX:0]   cnt_nxt;
  logic [INDEX:0]   ccnt_nxt;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  logic [1:0]       alloc_add;
  logic [1:0]       commit_add;
  logic             alloc_err;
  logic             commit_err;
  logic             drain_load;

  assign freeCnt_o   = (INDEX+1)'(DEPTH) - cnt;
  assign full_o      = freeCnt_o < (INDEX+1)'(2);
  assign empty_o     = (cnt == '0) && !out_valid;
  assign ramAddr_o   = head;
  assign dcValid_o   = out_valid;
  assign dcData_o    = out_data;
  assign commit_nxt  = commit_ptr + INDEX'(commit_add);

  // Legality checks and counter deltas; alloc uses the pre-drain free count.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    alloc_err  = 1'b0;
    commit_err = 1'b0;
    alloc_add  = 2'd0;
    commit_add = 2'd0;
    drain_load = (ccnt != '0) && (!out_valid || dcReady_i);

    if ((INDEX+1)'(commitCnt_i) > (cnt - ccnt)) begin
      commit_err = 1'b1;
    end else begin
      commit_add = commitCnt_i;
    end

    // A flush discards the dispatch slot entirely, so its alloc is not judged.
    if (!flush_i) begin
      if ((INDEX+1)'(allocCnt_i) > freeCnt_o) begin
        alloc_err = 1'b1;
      end else begin
        alloc_add = allocCnt_i;
      end
    end

    ccnt_nxt = ccnt + (INDEX+1)'(commit_add) - (INDEX+1)'(drain_load);
    if (flush_i) begin
      cnt_nxt = ccnt_nxt;
    end else begin
      cnt_nxt = cnt + (INDEX+1)'(alloc_add) - (INDEX+1)'(drain_load);
    end
  end

  stq_ptr_wrap #(.INDEX(INDEX)) u_head (
    .clk      (clk),
    .reset    (reset),
    .add      ({1'b0, drain_load}),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (head)
  );

  stq_ptr_wrap #(.INDEX(INDEX)) u_commit (
    .clk      (clk),
    .reset    (reset),
    .add      (commit_add),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (commit_ptr)
  );

  // On flush the tail snaps back to just past the youngest committed store.
  stq_ptr_wrap #(.INDEX(INDEX)) u_tail (
    .clk      (clk),
    .reset    (reset),
    .add      (alloc_add),
    .load     (flush_i),
    .load_val (commit_nxt),
    .ptr      (tail_o)
  );

  // Occupancy counters: alloc, commit and drain deltas land in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      ccnt <= '0;
    end else begin
      cnt  <= cnt_nxt;
      ccnt <= ccnt_nxt;
    end
  end

  // Output register: refill from RAM when free or being accepted, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (drain_load) begin
      out_valid <= 1'b1;
      out_data  <= ramData_i;
    end else if (out_valid && dcReady_i) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky protocol-violation flag for over-allocation or over-commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      errSticky_o <= 1'b0;
    end else if (alloc_err || commit_err) begin
      errSticky_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stq_drain_ctrl.sv
// Scenario bench for stq_drain_ctrl; drained payloads are scoreboarded.
module tb_stq_drain_ctrl;
  import stq_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   allocCnt_i;
  logic [1:0]   commitCnt_i;
  logic         flush_i;
  logic [3:0]   tail_o;
  stq_cnt_t     freeCnt_o;
  logic         full_o;
  logic         empty_o;
  logic [3:0]   ramAddr_o;
  stq_payload_t ramData_i;
  logic         dcValid_o;
  stq_payload_t dcData_o;
  logic         dcReady_i;
  logic         errSticky_o;

  stq_payload_t ram [16];
  stq_payload_t exp_q [$];
  logic [3:0]   cmt_idx;
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  assign ramData_i = ram[ramAddr_o];

  stq_drain_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .allocCnt_i  (allocCnt_i),
    .commitCnt_i (commitCnt_i),
    .flush_i     (flush_i),
    .tail_o      (tail_o),
    .freeCnt_o   (freeCnt_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .ramAddr_o   (ramAddr_o),
    .ramData_i   (ramData_i),
    .dcValid_o   (dcValid_o),
    .dcData_o    (dcData_o),
    .dcReady_i   (dcReady_i),
    .errSticky_o (errSticky_o)
  );

  // Every accepted cache request must match the oldest committed store.
  always @(negedge clk) begin : monitor
    stq_payload_t e;
    if (!reset && dcValid_o && dcReady_i) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL dc_unexpected: got %h, no store pending", dcData_o);
      end else begin
        e = exp_q.pop_front();
        if (dcData_o !== e) begin
          miscompares++;
          $display("FAIL dc_data: got %h expected %h", dcData_o, e);
        end
      end
    end
  end

  // One clock with the given alloc/commit/flush; commits queue their payloads.
  task automatic cycle(input logic [1:0] a, input logic [1:0] c, input logic f);
    allocCnt_i  = a;
    commitCnt_i = c;
    flush_i     = f;
    for (int k = 0; k < int'(c); k++) begin
      exp_q.push_back(ram[cmt_idx]);
      cmt_idx = cmt_idx + 4'd1;
    end
    @(posedge clk);
    #1;
    allocCnt_i  = 2'd0;
    commitCnt_i = 2'd0;
    flush_i     = 1'b0;
  endtask

  task automatic do_reset();
    dcReady_i   = 1'b0;
    allocCnt_i  = 2'd0;
    commitCnt_i = 2'd0;
    flush_i     = 1'b0;
    reset       = 1'b1;
    exp_q.delete();
    cmt_idx = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d stores left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({freeCnt_o, full_o, empty_o, dcValid_o, ramAddr_o, tail_o, errSticky_o}
        !== {5'd16, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: free=%0d full=%b empty=%b valid=%b addr=%0d tail=%0d err=%b",
               freeCnt_o, full_o, empty_o, dcValid_o, ramAddr_o, tail_o, errSticky_o);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 7; i++) cycle(2'd2, 2'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (freeCnt_o !== 5'd2 || full_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_free2: free=%0d full=%b expected 2/0", freeCnt_o, full_o);
    end
    cycle(2'd2, 2'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (tail_o !== 4'd0 || freeCnt_o !== 5'd0 || full_o !== 1'b1 || errSticky_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: tail=%0d free=%0d full=%b err=%b expected 0/0/1/0",
               tail_o, freeCnt_o, full_o, errSticky_o);
    end
    cycle(2'd1, 2'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (errSticky_o !== 1'b1 || tail_o !== 4'd0 || freeCnt_o !== 5'd0) begin
      miscompares++;
      $display("FAIL fill_overalloc: err=%b tail=%0d free=%0d expected 1/0/0",
               errSticky_o, tail_o, freeCnt_o);
    end
  endtask

  task automatic test_commit_err();
    do_reset();
    cycle(2'd1, 2'd0, 1'b0);
    commitCnt_i = 2'd2;
    @(posedge clk);
    #1;
    commitCnt_i = 2'd0;
    @(negedge clk);
    vectors++;
    if (errSticky_o !== 1'b1) begin
      miscompares++;
      $display("FAIL overcommit_err: err=%b expected 1", errSticky_o);
    end
    cycle(2'd0, 2'd0, 1'b0);
    cycle(2'd0, 2'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (dcValid_o !== 1'b0 || empty_o !== 1'b0 || freeCnt_o !== 5'd15) begin
      miscompares++;
      $display("FAIL overcommit_dropped: valid=%b empty=%b free=%0d expected 0/0/15",
               dcValid_o, empty_o, freeCnt_o);
    end
  endtask

  task automatic test_latency();
    do_reset();
    dcReady_i = 1'b1;
    cycle(2'd2, 2'd0, 1'b0);
    cycle(2'd1, 2'd0, 1'b0);
    cycle(2'd0, 2'd1, 1'b0);
    @(negedge clk);
    vectors++;
    if (dcValid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_n1: valid=%b expected 0", dcValid_o);
    end
    cycle(2'd0, 2'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (dcValid_o !== 1'b1 || dcData_o !== ram[0] || freeCnt_o !== 5'd14) begin
      miscompares++;
      $display("FAIL latency_n2: valid=%b data=%h free=%0d expected 1/%h/14",
               dcValid_o, dcData_o, freeCnt_o, ram[0]);
    end
    cycle(2'd0, 2'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (dcValid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_n3: valid=%b expected 0", dcValid_o);
    end
    wait_drain();
  endtask

  task automatic test_stall();
    do_reset();
    cycle(2'd2, 2'd0, 1'b0);
    cycle(2'd2, 2'd0, 1'b0);
    cycle(2'd0, 2'd2, 1'b0);
    cycle(2'd0, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) cycle(2'd0, 2'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (dcValid_o !== 1'b1 || dcData_o !== ram[0]) begin
      miscompares++;
      $display("FAIL stall_hold: valid=%b data=%h expected 1/%h", dcValid_o, dcData_o, ram[0]);
    end
    @(posedge clk);
    #1;
    dcReady_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (dcValid_o !== 1'b1 || dcData_o !== ram[i]) begin
        miscompares++;
        $display("FAIL stall_burst%0d: valid=%b data=%h expected 1/%h",
                 i, dcValid_o, dcData_o, ram[i]);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    vectors++;
    if (dcValid_o !== 1'b0 || empty_o !== 1'b1 || freeCnt_o !== 5'd16) begin
      miscompares++;
      $display("FAIL stall_end: valid=%b empty=%b free=%0d expected 0/1/16",
               dcValid_o, empty_o, freeCnt_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(2'd1, 2'd0, 1'b0);
    cycle(2'd0, 2'd1, 1'b0);
    cycle(2'd0, 2'd0, 1'b0);
    cycle(2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(2'd2, 2'd0, 1'b0);
    cycle(2'd0, 2'd2, 1'b0);
    cycle(2'd0, 2'd1, 1'b1);
    @(negedge clk);
    vectors++;
    if (tail_o !== 4'd4 || freeCnt_o !== 5'd13 || dcValid_o !== 1'b1 || dcData_o !== ram[0]) begin
      miscompares++;
      $display("FAIL flush_state: tail=%0d free=%0d valid=%b data=%h expected 4/13/1/%h",
               tail_o, freeCnt_o, dcValid_o, dcData_o, ram[0]);
    end
    cycle(2'd0, 2'd0, 1'b0);
    dcReady_i = 1'b1;
    wait_drain();
    @(negedge clk);
    vectors++;
    if (empty_o !== 1'b1 || freeCnt_o !== 5'd16 || tail_o !== 4'd4) begin
      miscompares++;
      $display("FAIL flush_drained: empty=%b free=%0d tail=%0d expected 1/16/4",
               empty_o, freeCnt_o, tail_o);
    end
  endtask

  task automatic test_full_drain();
    do_reset();
    dcReady_i = 1'b1;
    for (int i = 0; i < 8; i++) cycle(2'd2, 2'd0, 1'b0);
    cycle(2'd0, 2'd1, 1'b0);
    @(negedge clk);
    vectors++;
    if (errSticky_o !== 1'b0 || freeCnt_o !== 5'd0) begin
      miscompares++;
      $display("FAIL full_pre: err=%b free=%0d expected 0/0", errSticky_o, freeCnt_o);
    end
    cycle(2'd1, 2'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (errSticky_o !== 1'b1 || freeCnt_o !== 5'd1 || tail_o !== 4'd0) begin
      miscompares++;
      $display("FAIL full_drain_drop: err=%b free=%0d tail=%0d expected 1/1/0",
               errSticky_o, freeCnt_o, tail_o);
    end
    cycle(2'd1, 2'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (tail_o !== 4'd1 || freeCnt_o !== 5'd0) begin
      miscompares++;
      $display("FAIL full_realloc: tail=%0d free=%0d expected 1/0", tail_o, freeCnt_o);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(2'd1, 2'd0, 1'b0);
    cycle(2'd0, 2'd1, 1'b0);
    cycle(2'd0, 2'd0, 1'b0);
    cycle(2'd0, 2'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (dcValid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_pre: valid=%b expected 1", dcValid_o);
    end
    reset = 1'b1;
    exp_q.delete();
    cmt_idx = 4'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (dcValid_o !== 1'b0 || empty_o !== 1'b1 || freeCnt_o !== 5'd16) begin
      miscompares++;
      $display("FAIL midreset_post: valid=%b empty=%b free=%0d expected 0/1/16",
               dcValid_o, empty_o, freeCnt_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = stq_payload_t'(8'hA0 + i);
    test_reset();
    test_fill();
    test_commit_err();
    test_latency();
    test_stall();
    test_flush();
    test_full_drain();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stq_drain_ctrl.md
# stq_drain_ctrl

Store-queue occupancy and drain controller for the load/store unit. It owns the head, commit and tail pointers of the store queue and allocates entries at dispatch. It tracks which stores have committed and reads committed entries out of the two-read-port STQ RAM in program order. Each read entry is presented to the data cache through a one-entry valid/ready output register; the entry is freed once it is captured.

## Interface
Parameters:
- DEPTH, 16, store-queue entries; power of two, ≥4
- INDEX, 4, log2(DEPTH)
- WIDTH, 8, STQ RAM payload width (address+data+size, opaque here)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- allocCnt_i  in  2  stores allocated this cycle (0–2)
- commitCnt_i  in  2  stores retiring this cycle (0–2)
- flush_i  in  1  squash all uncommitted entries
- tail_o  out  INDEX  next allocation index (dispatch writes RAM at tail_o, tail_o+1)
- freeCnt_o  out  INDEX+1  free entries
- full_o  out  1  freeCnt_o < 2
- empty_o  out  1  no entries held and output register empty
- ramAddr_o  out  INDEX  STQ RAM read address (drives addr1_i)
- ramData_i  in  WIDTH  combinational read data for ramAddr_o
- dcValid_o  out  1  store request valid
- dcData_o  out  WIDTH  store payload
- dcReady_i  in  1  cache accepts request
- errSticky_o  out  1  sticky protocol-violation flag

## Operation
- State registers:
  - head, commitPtr, tail (INDEX bits, wrap mod DEPTH)
  - cnt: entries held in RAM (INDEX+1 bits)
  - ccnt: committed, not yet drained (INDEX+1 bits)
  - outValid, outData
- Reset: all pointers 0, cnt=ccnt=0, outValid=0, outData=0, errSticky_o=0. Output values after reset: freeCnt_o=DEPTH, full_o=0, empty_o=1, dcValid_o=0, ramAddr_o=0.
- Alloc: tail += allocCnt_i and cnt += allocCnt_i.
  - If allocCnt_i > freeCnt_o, the request is dropped entirely and errSticky_o is set.
- Commit: commitPtr += commitCnt_i and ccnt += commitCnt_i.
  - If commitCnt_i > cnt − ccnt, the commit is dropped and errSticky_o is set.
- Drain (load): ramAddr_o = head always. Load when ccnt≠0 and (!outValid or dcReady_i).
  - Action: outData ← ramData_i, outValid ← 1, head++, cnt−−, ccnt−−.
- Drain (handshake): when dcValid_o && dcReady_i and no load occurs, outValid ← 0.
- Flush: the same cycle's commit is applied first. Then tail ← new commitPtr, cnt ← new ccnt, and alloc is ignored. Committed stores and the output register are unaffected.
- Arithmetic: all pointer adds are modulo DEPTH. Counts never wrap; over-run is blocked by the checks above. freeCnt_o = DEPTH − cnt.

## Timing
- All outputs are registered state or derived combinationally from registered state only. ramAddr_o must not depend on dcReady_i.
- Commit at cycle N → ccnt visible cycle N+1 → RAM read and capture at end of N+1 → dcValid_o high in cycle N+2.
- Throughput: one store per cycle while ccnt>0 and dcReady_i=1.
- Entry free latency: a slot freed by drain at edge E is reflected in freeCnt_o after E. An alloc in the same cycle sees the pre-drain freeCnt_o.
- dcValid_o/dcData_o hold stable until accepted; there is no retraction.
- Reset mid-operation (including dcValid_o=1 with dcReady_i=0) returns to reset state next edge. The pending request is discarded.
- Simultaneous alloc + commit + drain in one cycle: all three counter deltas are applied in the same edge.

## Structure
- Package stq_pkg: DEPTH/INDEX defaults, the payload typedef stq_payload_t (WIDTH bits), and the count typedef stq_cnt_t (INDEX+1 bits).
- One sub-module: stq_ptr_wrap, a modulo-DEPTH pointer register with add of 0–2 and load. It is instantiated for head, commitPtr and tail.

## Test plan
- Reset, then alloc 2/cycle for 8 cycles → tail_o=0 (wrapped), freeCnt_o=0, full_o=1. A 9th alloc of 1 → dropped, errSticky_o=1.
- Alloc 3 entries, commit 1 at cycle N, dcReady_i=1 → dcValid_o=1 exactly in cycle N+2 with dcData_o = RAM[0]. freeCnt_o returns to DEPTH−2.
- Commit 4 with dcReady_i=0 → dcValid_o held with the RAM[0] payload. Raise dcReady_i → payloads RAM[1..3] appear on consecutive cycles, then dcValid_o=0.
- Alloc 6, commit 2, flush_i with commitCnt_i=1 same cycle → tail_o=head+3, freeCnt_o=DEPTH−3, and all three committed stores drain.
- Full queue (cnt=16) with one drain and allocCnt_i=1 in the same cycle → alloc dropped, errSticky_o=1. The next cycle alloc 1 succeeds.
- Assert reset while dcValid_o=1 and dcReady_i=0 → next cycle dcValid_o=0, empty_o=1, freeCnt_o=16.
